// File: rtl/prog_loader_if.sv
// Bundle for the loader's byte stream and BRAM write port.
// The loader takes the slave side. The producer and the BRAM take the master side.
interface prog_loader_if #(
  parameter int ADDR_W = 10
);
  // Byte stream into the loader
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  // Word write port out of the loader
  logic [ADDR_W-1:0] bram_addr;
  logic [31:0]       bram_din;
  logic              bram_we;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready,
    input  bram_addr,
    input  bram_din,
    input  bram_we
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready,
    output bram_addr,
    output bram_din,
    output bram_we
  );
endinterface

// File: rtl/prog_loader.sv
// Boot program loader. It receives a framed byte stream:
//   COUNT (16-bit LE word count N), N little-endian 32-bit words, XOR checksum.
// It writes each word into BRAM and keeps the CPU in reset until the frame
// arrives complete with a good checksum.
// Every output is registered and is decoded from the next state. The outputs
// therefore change on the same edge as the state.
module prog_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic         ap_clk,
  input  logic         ap_rst_n,
  prog_loader_if.slave bus,
  input  logic         restart,
  output logic         cpu_rst,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    HDR0  = 3'd0,
    HDR1  = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_e;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_e            state_q, state_d;
  logic [15:0]       count_q;
  logic [ADDR_W-1:0] word_idx_q;
  logic [1:0]        byte_idx_q;
  logic [7:0]        csum_q;
  logic [7:0]        csum_d;
  logic [31:0]       word_q;
  logic [ADDR_W-1:0] bram_addr_q;
  logic [31:0]       bram_din_q;
  logic              bram_we_q;
  logic              s_ready_q;
  logic              cpu_rst_q;
  logic              done_q;
  logic              err_q;

  logic              accept;
  logic [15:0]       count_d;
  logic              last_word;
  logic              count_bad;

  // A byte moves only when the registered ready and the producer's valid are both high.
  assign accept    = bus.s_valid & s_ready_q;
  // Full word count as it would look once the byte now presented is taken as the high byte.
  assign count_d   = {bus.s_data, count_q[7:0]};
  assign count_bad = (count_d == 16'd0) || ({1'b0, count_d} > DEPTH_L);
  // word_idx_q never exceeds N-1 while in DATA, so a zero-extended compare is exact.
  assign last_word = (16'(word_idx_q) == (count_q - 16'd1));

  // Next state and running checksum
  always_comb begin
    state_d = state_q;
    csum_d  = csum_q ^ bus.s_data;
    case (state_q)
      HDR0: begin
        if (accept) state_d = HDR1;
      end
      HDR1: begin
        if (accept) state_d = count_bad ? ERROR : DATA;
      end
      DATA: begin
        if (accept && (byte_idx_q == 2'd3) && last_word) state_d = CSUM;
      end
      CSUM: begin
        if (accept) state_d = (bus.s_data == csum_q) ? DONE : ERROR;
      end
      DONE, ERROR: begin
        if (restart) state_d = HDR0;
      end
      default: state_d = HDR0;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= HDR0;
      count_q     <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      csum_q      <= '0;
      word_q      <= '0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      bram_we_q   <= 1'b0;
      s_ready_q   <= 1'b0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d != DONE) && (state_d != ERROR);
      cpu_rst_q <= (state_d != DONE);
      done_q    <= (state_d == DONE);
      err_q     <= (state_d == ERROR);
      // The strobe is high only in the cycle after a word's fourth byte.
      bram_we_q <= 1'b0;

      case (state_q)
        HDR0: begin
          if (accept) begin
            count_q[7:0] <= bus.s_data;
            csum_q       <= csum_d;
          end
        end
        HDR1: begin
          if (accept) begin
            count_q[15:8] <= bus.s_data;
            csum_q        <= csum_d;
            word_idx_q    <= '0;
            byte_idx_q    <= '0;
          end
        end
        DATA: begin
          if (accept) begin
            csum_q     <= csum_d;
            byte_idx_q <= byte_idx_q + 2'd1;
            word_q[{byte_idx_q, 3'b000} +: 8] <= bus.s_data;
            if (byte_idx_q == 2'd3) begin
              // The fourth byte goes straight into the write data. The next
              // word's first byte can then arrive on the following edge while
              // this write is still on the port.
              bram_we_q   <= 1'b1;
              bram_addr_q <= word_idx_q;
              bram_din_q  <= {bus.s_data, word_q[23:0]};
              word_idx_q  <= word_idx_q + ADDR_W'(1);
            end
          end
        end
        CSUM: begin
          // The checksum byte is compared in the next-state logic. Nothing else is stored.
        end
        DONE, ERROR: begin
          if (restart) begin
            csum_q     <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.bram_addr = bram_addr_q;
  assign bus.bram_din  = bram_din_q;
  assign bus.bram_we   = bram_we_q;
  assign cpu_rst       = cpu_rst_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader.
// The stimulus side works out each frame's expected BRAM writes from the frame
// format and queues them. A monitor pops one entry for every write strobe it sees.
`timescale 1ns/1ps
module tb_prog_loader;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;
  typedef logic [7:0] u8;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  logic restart  = 1'b0;
  logic cpu_rst, done, err;

  prog_loader_if #(.ADDR_W(ADDR_W)) bus();

  prog_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .bus     (bus.slave),
    .restart (restart),
    .cpu_rst (cpu_rst),
    .done    (done),
    .err     (err)
  );

  always #5 ap_clk = ~ap_clk;

  int vectors     = 0;
  int miscompares = 0;
  int writes_seen = 0;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [31:0]       exp_data_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge and matches every write against the scoreboard.
  always @(negedge ap_clk) begin
    check("done_err_exclusive", {31'd0, done & err}, 32'd0);
    if (bus.bram_we === 1'b1) begin
      writes_seen++;
      if (exp_addr_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%08h, none expected", bus.bram_addr, bus.bram_din);
      end else begin
        logic [ADDR_W-1:0] ea;
        logic [31:0]       ed;
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        check("bram_addr", 32'(bus.bram_addr), 32'(ea));
        check("bram_din", bus.bram_din, ed);
        $display("write addr=0x%0h data=0x%08h", bus.bram_addr, bus.bram_din);
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic u8 xor_of(input u8 f[$], input int n);
    u8 x = 8'h00;
    for (int i = 0; i < n; i++) x = x ^ f[i];
    return x;
  endfunction

  // Reads the frame and queues its writes. Reports whether the frame should end in DONE.
  task automatic expect_frame(input u8 f[$], output bit exp_done);
    int n;
    exp_done = 1'b0;
    n = int'({f[1], f[0]});
    if (n == 0 || n > DEPTH) return;
    for (int w = 0; w < n; w++) begin
      int b = 2 + 4 * w;
      exp_addr_q.push_back(ADDR_W'(w));
      exp_data_q.push_back({f[b+3], f[b+2], f[b+1], f[b]});
    end
    exp_done = (f[2 + 4 * n] == xor_of(f, 2 + 4 * n));
  endtask

  function automatic void make_frame(input int n, input bit bad, output u8 f[$]);
    u8 c;
    f = {};
    f.push_back(u8'(n & 255));
    f.push_back(u8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) f.push_back(u8'($urandom));
    c = xor_of(f, f.size());
    if (bad) c = c ^ u8'($urandom_range(255, 1));
    f.push_back(c);
  endfunction

  // ---------------- stimulus ----------------
  // Presents the bytes with valid high on pct% of cycles. restart is held high
  // while byte index restart_at is pending.
  task automatic send(input u8 f[$], input int pct, input int restart_at);
    int i = 0;
    int guard = 0;
    bit go, taken;
    while (i < f.size() && guard < 30000) begin
      go = ($urandom_range(99) < pct);
      bus.s_valid = go;
      bus.s_data  = go ? f[i] : u8'($urandom);
      restart     = (i == restart_at);
      taken       = go && (bus.s_ready === 1'b1);
      tick();
      if (taken) i++;
      guard++;
    end
    bus.s_valid = 1'b0;
    restart     = 1'b0;
    if (i < f.size()) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: accepted %0d of %0d bytes", i, f.size());
    end
  endtask

  task automatic check_final(input string name, input bit exp_done);
    tick();
    tick();
    check({name, "_done"},    {31'd0, done},      {31'd0, exp_done});
    check({name, "_err"},     {31'd0, err},       {31'd0, !exp_done});
    check({name, "_cpu_rst"}, {31'd0, cpu_rst},   {31'd0, !exp_done});
    check({name, "_s_ready"}, {31'd0, bus.s_ready}, 32'd0);
    check({name, "_pending"}, 32'(exp_addr_q.size()), 32'd0);
    $display("frame %s: done=%0b err=%0b cpu_rst=%0b", name, done, err, cpu_rst);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_cpu_rst", {31'd0, cpu_rst},     32'd1);
    check("restart_s_ready", {31'd0, bus.s_ready}, 32'd1);
    check("restart_done",    {31'd0, done},        32'd0);
    check("restart_err",     {31'd0, err},         32'd0);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_s_ready"},   {31'd0, bus.s_ready}, 32'd0);
    check({name, "_bram_we"},   {31'd0, bus.bram_we}, 32'd0);
    check({name, "_bram_addr"}, 32'(bus.bram_addr),   32'd0);
    check({name, "_bram_din"},  bus.bram_din,         32'd0);
    check({name, "_cpu_rst"},   {31'd0, cpu_rst},     32'd1);
    check({name, "_done"},      {31'd0, done},        32'd0);
    check({name, "_err"},       {31'd0, err},         32'd0);
  endtask

  task automatic release_reset();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    check("ready_before_edge", {31'd0, bus.s_ready}, 32'd0);
    tick();
    check("ready_after_edge", {31'd0, bus.s_ready}, 32'd1);
  endtask

  initial begin
    u8  base[$];
    u8  f[$];
    u8  hdr[$];
    bit exp_done;
    int wbefore;

    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;

    // Reset state
    #12;
    check_reset_values("reset");
    release_reset();

    // Directed two-word frame. The good checksum is the XOR of its bytes (0xF2).
    base = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'hB3, 8'h00, 8'h00, 8'h00};
    f = base;
    f.push_back(xor_of(base, base.size()));
    expect_frame(f, exp_done);
    check("directed_w0", exp_data_q[0], 32'h00500013);
    check("directed_w1", exp_data_q[1], 32'h000000B3);
    send(f, 100, -1);
    check_final("directed_good", exp_done);
    check("directed_good_done_expected", {31'd0, exp_done}, 32'd1);

    // Same frame, checksum 0x00
    do_restart();
    f = base;
    f.push_back(8'h00);
    expect_frame(f, exp_done);
    send(f, 100, -1);
    check_final("directed_bad_csum", exp_done);

    // COUNT = 0. Then bytes offered while ready is low must be ignored.
    do_restart();
    hdr = '{8'h00, 8'h00};
    wbefore = writes_seen;
    send(hdr, 100, -1);
    check_final("count_zero", 1'b0);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h55;
    repeat (4) tick();
    bus.s_valid = 1'b0;
    check("ignored_bytes_err", {31'd0, err}, 32'd1);
    check("count_zero_no_writes", 32'(writes_seen - wbefore), 32'd0);

    // COUNT = 1025
    do_restart();
    hdr = '{8'h01, 8'h04};
    wbefore = writes_seen;
    send(hdr, 100, -1);
    check_final("count_over", 1'b0);
    check("count_over_no_writes", 32'(writes_seen - wbefore), 32'd0);

    // Directed frame with a randomly stalled stream
    do_restart();
    f = base;
    f.push_back(xor_of(base, base.size()));
    expect_frame(f, exp_done);
    send(f, 50, -1);
    check_final("directed_stalled", exp_done);

    // Reset after the 6th byte, then resend the whole frame
    do_restart();
    hdr = {};
    for (int i = 0; i < 6; i++) hdr.push_back(base[i]);
    send(hdr, 100, -1);
    ap_rst_n = 1'b0;
    #2;
    check_reset_values("mid_frame_reset");
    release_reset();
    expect_frame(f, exp_done);
    send(f, 100, -1);
    check_final("after_reset", exp_done);

    // Restart from DONE, then a one-word frame with restart pulsed during DATA
    do_restart();
    make_frame(1, 1'b0, f);
    expect_frame(f, exp_done);
    send(f, 100, 3);
    check_final("restart_ignored", exp_done);

    // Largest legal frame: the last write lands on DEPTH-1
    do_restart();
    make_frame(DEPTH, 1'b0, f);
    expect_frame(f, exp_done);
    send(f, 100, -1);
    check_final("full_depth", exp_done);

    // Random frames
    for (int k = 0; k < 8; k++) begin
      do_restart();
      make_frame(int'($urandom_range(12, 1)), ($urandom_range(3) == 0), f);
      expect_frame(f, exp_done);
      send(f, int'($urandom_range(100, 30)), -1);
      check_final("random", exp_done);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Overall time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
